// File: rtl/branch_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : branch_cmp_pipe
//  Brief    : Pipelined multi-mode branch-condition unit (EQ/NE/LEZ/GTZ/LTZ/
//             GEZ/LT/LTU) with valid/ready handshake and synchronous flush.
//             Optional statistics counters built when BRANCH_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LEZ = 3'b010;
  localparam logic [2:0] OP_GTZ = 3'b011;
  localparam logic [2:0] OP_LTZ = 3'b100;
  localparam logic [2:0] OP_GEZ = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  localparam int LAST = STAGES - 1;

  // Input-side comparator
  logic cmp_eq;
  logic rs_neg;
  logic rs_zero;
  logic cmp_slt;
  logic cmp_ult;
  logic cond;

  always_comb begin
    cmp_eq  = (rs == rt);
    rs_neg  = rs[WIDTH-1];
    rs_zero = (rs == '0);
    cmp_slt = ($signed(rs) < $signed(rt));
    cmp_ult = (rs < rt);
    cond    = 1'b0;
    case (op)
      OP_EQ:   cond = cmp_eq;
      OP_NE:   cond = !cmp_eq;
      OP_LEZ:  cond = rs_neg || rs_zero;
      OP_GTZ:  cond = !rs_neg && !rs_zero;
      OP_LTZ:  cond = rs_neg;
      OP_GEZ:  cond = !rs_neg;
      OP_LT:   cond = cmp_slt;
      OP_LTU:  cond = cmp_ult;
      default: cond = 1'b0;
    endcase
  end

  // Per-stage state: one valid bit plus the {taken, eq} pair
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] taken_q, taken_d;
  logic [STAGES-1:0] eq_q,    eq_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_taken;
  logic [STAGES-1:0] src_eq;
  logic              stage0_free;
  logic              accept;

  // Walk from the output back to stage 0: a stage advances when whatever
  // sits downstream of it can take a new entry this cycle.
  always_comb begin : p_flow
    logic free;
    logic a;
    adv  = '0;
    free = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      a      = valid_q[k] && free;
      adv[k] = a;
      free   = !valid_q[k] || a;
    end
    stage0_free = free;
  end

  assign in_ready = !reset && !flush && stage0_free;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign load[k]      = accept;
      assign src_taken[k] = cond;
      assign src_eq[k]    = cmp_eq;
    end else begin : g_tail
      assign load[k]      = adv[k-1];
      assign src_taken[k] = taken_q[k-1];
      assign src_eq[k]    = eq_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    eq_d    = eq_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = 1'b1;
        taken_d[k] = src_taken[k];
        eq_d[k]    = src_eq[k];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      taken_q <= '0;
      eq_q    <= '0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      eq_q    <= eq_d;
    end
  end

  // Stored data is masked so idle outputs read as zero
  assign out_valid = valid_q[LAST];
  assign taken     = valid_q[LAST] && taken_q[LAST];
  assign eq        = valid_q[LAST] && eq_q[LAST];

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             out_hs;

  // A result leaving during a flush cycle is discarded, so it is not counted
  always_comb begin
    out_hs      = out_valid && out_ready && !flush;
    total_cnt_d = total_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (out_hs) begin
      if (total_cnt_q != '1) begin
        total_cnt_d = total_cnt_q + CNT_W'(1);
      end
      if (taken && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      total_cnt_q <= total_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign total_cnt = total_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign total_cnt = '0;
  assign taken_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_cmp_pipe
//  Brief    : Scoreboard bench for branch_cmp_pipe; one STAGES=1/CNT_W=4
//             instance and one STAGES=2 instance driven by directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_cmp_pipe;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LEZ = 3'b010;
  localparam logic [2:0] OP_GTZ = 3'b011;
  localparam logic [2:0] OP_LTZ = 3'b100;
  localparam logic [2:0] OP_GEZ = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1, taken1, eq1;
  logic [2:0]  op1;
  logic [31:0] rs1, rt1;
  logic [3:0]  tot1, tkn1;

  logic        in_valid2, in_ready2, flush2, out_valid2, out_ready2, taken2, eq2;
  logic [2:0]  op2;
  logic [31:0] rs2, rt2;
  logic [15:0] tot2, tkn2;

  int checks = 0;
  int errors = 0;

  logic [1:0] q1[$];
  logic [1:0] q2[$];
  int m_tot1 = 0, m_tkn1 = 0, m_tot2 = 0, m_tkn2 = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .rs(rs1), .rt(rt1), .flush(flush1), .out_valid(out_valid1),
    .out_ready(out_ready1), .taken(taken1), .eq(eq1),
    .total_cnt(tot1), .taken_cnt(tkn1)
  );

  branch_cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .rs(rs2), .rt(rt2), .flush(flush2), .out_valid(out_valid2),
    .out_ready(out_ready2), .taken(taken2), .eq(eq2),
    .total_cnt(tot2), .taken_cnt(tkn2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!reset && !flush1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_result actual=%0b required=none", {taken1, eq1});
      end else begin
        logic [1:0] e;
        e = q1.pop_front();
        chk("dut1_result", {30'd0, taken1, eq1}, {30'd0, e});
        m_tot1++;
        if (e[1]) m_tkn1++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && !flush2 && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected_result actual=%0b required=none", {taken2, eq2});
      end else begin
        logic [1:0] e;
        e = q2.pop_front();
        chk("dut2_result", {30'd0, taken2, eq2}, {30'd0, e});
        m_tot2++;
        if (e[1]) m_tkn2++;
      end
    end
  end

  task automatic send1(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] exp, output int waited);
    waited = 0;
    in_valid1 = 1'b1; op1 = o; rs1 = a; rt1 = b;
    forever begin
      @(negedge clk);
      if (in_ready1) break;
      waited++;
      if (waited > 50) break;
    end
    if (in_ready1) q1.push_back(exp);
    else begin
      checks++; errors++;
      $display("FAIL dut1_accept_timeout actual=in_ready0 required=in_ready1");
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] exp, output int waited);
    waited = 0;
    in_valid2 = 1'b1; op2 = o; rs2 = a; rt2 = b;
    forever begin
      @(negedge clk);
      if (in_ready2) break;
      waited++;
      if (waited > 50) break;
    end
    if (in_ready2) q2.push_back(exp);
    else begin
      checks++; errors++;
      $display("FAIL dut2_accept_timeout actual=in_ready0 required=in_ready1");
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    in_valid1 = 0; flush1 = 0; out_ready1 = 0; op1 = 0; rs1 = 0; rt1 = 0;
    in_valid2 = 0; flush2 = 0; out_ready2 = 0; op2 = 0; rs2 = 0; rt2 = 0;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready1", in_ready1, 0);
      chk("rst_in_ready2", in_ready2, 0);
      chk("rst_out_valid1", out_valid1, 0);
      chk("rst_out_valid2", out_valid2, 0);
      chk("rst_taken_eq1", {taken1, eq1}, 0);
      chk("rst_cnt1", {tot1, tkn1}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready1", in_ready1, 1);
    chk("post_rst_in_ready2", in_ready2, 1);
    @(posedge clk); #1;

    // Reset mid-operation drops in-flight results
    send1(OP_EQ, 32'd1, 32'd1, 2'b11, w);
    send2(OP_EQ, 32'd1, 32'd1, 2'b11, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q1.delete(); q2.delete();
    @(negedge clk);
    chk("midrst_out_valid1", out_valid1, 0);
    chk("midrst_out_valid2", out_valid2, 0);
    chk("midrst_in_ready1", in_ready1, 1);
    @(posedge clk); #1;

    // STAGES=1 streaming, simultaneous consume and accept every cycle
    out_ready1 = 1'b1;
    send1(OP_EQ,  32'd5, 32'd5,         2'b11, w); chk("s1_stream_wait", w, 0);
    send1(OP_NE,  32'd5, 32'd5,         2'b01, w); chk("s1_stream_wait", w, 0);
    send1(OP_LTU, 32'd1, 32'hFFFF_FFFF, 2'b10, w); chk("s1_stream_wait", w, 0);
    send1(OP_LT,  32'd1, 32'hFFFF_FFFF, 2'b00, w); chk("s1_stream_wait", w, 0);
    repeat (2) @(negedge clk);
`ifdef BRANCH_STATS_EN
    chk("s1_total_cnt", tot1, 4);
    chk("s1_taken_cnt", tkn1, 2);
`else
    chk("s1_total_cnt_off", tot1, 0);
    chk("s1_taken_cnt_off", tkn1, 0);
`endif
    @(posedge clk); #1;

    // Sign boundaries and signed/unsigned contrast
    send1(OP_LEZ, 32'd0,         32'd0,         2'b11, w);
    send1(OP_GTZ, 32'h8000_0000, 32'd0,         2'b00, w);
    send1(OP_LTZ, 32'h8000_0000, 32'd0,         2'b10, w);
    send1(OP_GEZ, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b11, w);
    send1(OP_LT,  32'hFFFF_FFFF, 32'd1,         2'b10, w);
    send1(OP_LTU, 32'hFFFF_FFFF, 32'd1,         2'b00, w);
    send1(OP_GTZ, 32'd1,         32'd2,         2'b10, w);
    send1(OP_LEZ, 32'hFFFF_FFFF, 32'd0,         2'b10, w);
    repeat (2) @(negedge clk);
`ifdef BRANCH_STATS_EN
    chk("s1_total_cnt_model", tot1, sat(m_tot1, 15));
    chk("s1_taken_cnt_model", tkn1, sat(m_tkn1, 15));
`endif
    @(posedge clk); #1;

    // STAGES=2 backpressure
    out_ready2 = 1'b0;
    send2(OP_EQ,  32'd3, 32'd3, 2'b11, w);
    send2(OP_LTU, 32'd2, 32'd1, 2'b00, w);
    chk("s2_second_accept_wait", w, 0);
    repeat (3) begin
      @(negedge clk);
      chk("s2_bp_in_ready", in_ready2, 0);
      chk("s2_bp_out_valid", out_valid2, 1);
      chk("s2_bp_held", {taken2, eq2}, 2'b11);
    end
    @(posedge clk); #1;
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("s2_drain_first", {out_valid2, taken2, eq2}, 3'b111);
    @(negedge clk);
    chk("s2_drain_second", {out_valid2, taken2, eq2}, 3'b100);
    @(negedge clk);
    chk("s2_drain_empty", {out_valid2, taken2, eq2}, 3'b000);
    @(posedge clk); #1;

    // STAGES=2 sustained throughput
    send2(OP_GTZ, 32'd1,         32'd1,         2'b11, w); chk("s2_stream_wait", w, 0);
    send2(OP_LEZ, 32'hFFFF_FFFF, 32'd0,         2'b10, w); chk("s2_stream_wait", w, 0);
    send2(OP_NE,  32'd7,         32'd8,         2'b10, w); chk("s2_stream_wait", w, 0);
    send2(OP_GEZ, 32'h8000_0000, 32'd0,         2'b00, w); chk("s2_stream_wait", w, 0);
    send2(OP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 2'b10, w); chk("s2_stream_wait", w, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Flush with two results in flight; output handshake in flush cycle
    out_ready2 = 1'b0;
    send2(OP_EQ, 32'd9, 32'd9, 2'b11, w);
    send2(OP_NE, 32'd9, 32'd9, 2'b01, w);
    flush2 = 1'b1; out_ready2 = 1'b1;
    in_valid2 = 1'b1; op2 = OP_EQ; rs2 = 32'd1; rt2 = 32'd1;
    @(negedge clk);
    chk("flush_in_ready", in_ready2, 0);
    @(posedge clk); #1;
    flush2 = 1'b0; in_valid2 = 1'b0;
    q2.delete();
    @(negedge clk);
    chk("flush_out_valid", {out_valid2, taken2, eq2}, 3'b000);
    repeat (3) @(negedge clk);
    chk("flush_stays_empty", out_valid2, 0);
`ifdef BRANCH_STATS_EN
    chk("s2_total_cnt", tot2, m_tot2);
    chk("s2_taken_cnt", tkn2, m_tkn2);
`else
    chk("s2_total_cnt_off", tot2, 0);
    chk("s2_taken_cnt_off", tkn2, 0);
`endif
    @(posedge clk); #1;

    // Counter saturation with CNT_W=4
    for (int i = 0; i < 20; i++) begin
      send1(OP_EQ, 32'(i), 32'(i), 2'b11, w);
    end
    repeat (2) @(negedge clk);
`ifdef BRANCH_STATS_EN
    chk("sat_total_cnt", tot1, 15);
    chk("sat_taken_cnt", tkn1, 15);
`else
    chk("sat_total_cnt_off", tot1, 0);
    chk("sat_taken_cnt_off", tkn1, 0);
`endif

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_cmp_pipe.md
# branch_cmp_pipe

Parametrised, pipelined branch-condition unit for the MIPS datapath. It replaces the single-purpose equality comparator with a multi-mode comparator covering the EQ, NE, LEZ, GTZ, LTZ, GEZ, LT and LTU branch conditions. It sits between the ID-stage forwarding muxes and the PC-select logic. It carries results through STAGES registered stages under a valid/ready handshake, and supports a synchronous flush for pipeline redirects.

## Interface
- WIDTH, 32, operand width in bits (≥2).
- STAGES, 1, number of result register stages (1 or 2).
- CNT_W, 16, statistics counter width (used only with BRANCH_STATS_EN).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  unit accepts this cycle; transfer when in_valid && in_ready.
- op  in  3  condition select (see Operation).
- rs  in  WIDTH  first operand (forwarded).
- rt  in  WIDTH  second operand (forwarded; ignored by single-operand ops).
- flush  in  1  discard all in-flight results.
- out_valid  out  1  result available at the last stage.
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready.
- taken  out  1  condition outcome for the presented result.
- eq  out  1  rs == rt for the same transaction, independent of op.
- total_cnt  out  CNT_W  results consumed (stats build only).
- taken_cnt  out  CNT_W  taken results consumed (stats build only).

## Operation
- op encoding:
  - 000 EQ: rs==rt.
  - 001 NE: rs!=rt.
  - 010 LEZ: signed rs≤0.
  - 011 GTZ: signed rs>0.
  - 100 LTZ: rs[WIDTH-1].
  - 101 GEZ: !rs[WIDTH-1].
  - 110 LT: signed rs<rt.
  - 111 LTU: unsigned rs<rt.
- Compare logic is combinational at the input. Only {taken, eq} are stored per stage, plus one valid bit per stage.
- Stage k advances when stage k+1 is empty or stage k+1 advances. The last stage advances on out_ready.
- in_ready = !reset && !flush && (stage 1 empty || stage 1 advances).
- flush: all valid bits clear at the next edge. An input presented in the flush cycle is not accepted, because in_ready=0. A result handshaking in the flush cycle is not counted.
- No bubbles: with out_ready held at 1, one result per cycle is sustained.
- Held outputs: taken and eq hold their value while out_valid && !out_ready. When out_valid=0 they are 0.

## Timing
- Reset values (after the edge with reset=1):
  - all stage valid bits 0, so out_valid=0.
  - taken=0, eq=0.
  - counters 0.
- in_ready is 0 in any cycle with reset=1. It is 1 the first cycle after reset deasserts.
- Latency: an input accepted at edge N presents out_valid=1 after edge N+STAGES-1+1. That is, out_valid is visible STAGES cycles after the accept cycle.
- Backpressure: out_ready=0 with all stages full gives in_ready=0 in the same cycle (combinational path from out_ready).
- Simultaneous consume and accept with STAGES=1 and full: both occur in the same cycle, and the new result replaces the old.
- Reset mid-operation drops all in-flight results. Reset takes priority over flush and over the handshake.
- Counters saturate at all-ones and do not wrap.

## Configuration
- BRANCH_STATS_EN defined:
  - total_cnt increments on each output handshake.
  - taken_cnt increments on each output handshake with taken=1.
  - Both saturate and both are cleared by reset.
- BRANCH_STATS_EN undefined:
  - counters are not built.
  - total_cnt and taken_cnt are driven constant 0.
  - all other behaviour is identical.

## Test plan
- Reset held 2 cycles, then released: out_valid=0, taken=0, eq=0, in_ready=0 during reset and 1 the cycle after.
- STAGES=1, out_ready=1. Stream op=EQ rs=5 rt=5, then op=NE rs=5 rt=5, then op=LTU rs=1 rt=32'hFFFF_FFFF, then op=LT rs=1 rt=32'hFFFF_FFFF. Required outputs on consecutive cycles: taken=1/0/1/0, and eq=1,1,0,0.
- Sign boundaries, WIDTH=32:
  - LEZ rs=0 → 1.
  - GTZ rs=32'h8000_0000 → 0.
  - LTZ rs=32'h8000_0000 → 1.
  - GEZ rs=32'h7FFF_FFFF → 1.
- STAGES=2 backpressure:
  - Accept two inputs, then hold out_ready=0 for 3 cycles. Required: in_ready=0 while both stages are full, and the first result is held unchanged.
  - Then raise out_ready. Required: both results drain in order on consecutive cycles.
- Flush with 2 results in flight: out_valid=0 the next cycle, and the input offered during the flush cycle is not accepted. With BRANCH_STATS_EN, the counters are unchanged.
- BRANCH_STATS_EN, CNT_W=4: consume 20 taken results. Required: total_cnt=15 and taken_cnt=15, saturated.
